// File: rtl/uart_transmit_param_if.sv
// -----------------------------------------------------------------------------
// uart_transmit_param_if
// Word handshake between an on-chip producer and the parametrised UART
// transmitter.
//   tx_valid  producer -> transmitter  a word is present on tx_data
//   tx_data   producer -> transmitter  word to send (DATA_BITS wide)
//   tx_ready  transmitter -> producer  holding register empty
// A word transfers on a rising clk edge where tx_valid && tx_ready.
// Modports: master = producer side, slave = transmitter side.
// -----------------------------------------------------------------------------
interface uart_transmit_param_if #(
  parameter int DATA_BITS = 8
);
  logic                 tx_valid;
  logic [DATA_BITS-1:0] tx_data;
  logic                 tx_ready;

  modport master (
    output tx_valid,
    output tx_data,
    input  tx_ready
  );

  modport slave (
    input  tx_valid,
    input  tx_data,
    output tx_ready
  );
endinterface

// File: rtl/uart_transmit_param.sv
// -----------------------------------------------------------------------------
// uart_transmit_param
// Parametrised UART transmitter with a one-word holding register so that
// frames can be sent back-to-back with no idle time between them.
//
// Parameters
//   DATA_BITS     data bits per frame (5..9), sent LSB first
//   CLKS_PER_BIT  clk cycles per bit (>= 2)
//   PARITY        0 = none, 1 = odd, 2 = even
//   STOP_BITS     1 or 2
//
// Ports
//   clk      system clock, rising edge
//   rst      synchronous reset, active high
//   bus      slave side of the valid/ready word handshake
//   uart_tx  serial line, idle high, registered
//   busy     frame in progress or word held (forced low during reset)
// -----------------------------------------------------------------------------
module uart_transmit_param #(
  parameter int DATA_BITS    = 8,
  parameter int CLKS_PER_BIT = 10416,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                        clk,
  input  logic                        rst,
  uart_transmit_param_if.slave        bus,
  output logic                        uart_tx,
  output logic                        busy
);

  // Reject parameter sets the frame logic cannot represent.
  if (DATA_BITS < 5 || DATA_BITS > 9 || PARITY < 0 || PARITY > 2 ||
      STOP_BITS < 1 || STOP_BITS > 2 || CLKS_PER_BIT < 2) begin : g_bad_params
    $error("uart_transmit_param: illegal parameter combination");
  end

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int IDX_W = $clog2(DATA_BITS);

  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_BITS - 1);
  localparam logic             STOP_LAST = 1'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t               state;
  logic [DATA_BITS-1:0] hold;
  logic                 hold_full;
  logic [DATA_BITS-1:0] shifter;
  logic                 par_bit;
  logic [CNT_W-1:0]     baud_cnt;
  logic [IDX_W-1:0]     bit_idx;
  logic                 stop_cnt;
  logic                 tx_q;

  logic accept;
  logic bit_end;
  logic frame_end;
  logic load;
  logic par_next;

  // NOTE: tx_ready is combinational from the hold flag and rst so a producer
  // sees the slot free in the same cycle it empties; it is never registered.
  assign bus.tx_ready = ~hold_full & ~rst;
  assign accept       = bus.tx_valid & bus.tx_ready;

  assign bit_end   = (baud_cnt == CNT_LAST);
  assign frame_end = (state == S_STOP) && bit_end && (stop_cnt == STOP_LAST);
  // The shifter takes the held word either from idle or on the very last
  // cycle of the final stop bit, which removes any gap between frames.
  assign load      = hold_full && ((state == S_IDLE) || frame_end);

  // Odd parity makes the total count of ones odd, even makes it even.
  assign par_next  = (PARITY == 1) ? ~^hold : ^hold;

  assign uart_tx = tx_q;
  assign busy    = ~rst & ((state != S_IDLE) | hold_full);

  // NOTE: all state below uses non-blocking assignments so every register
  // samples the pre-edge values; blocking here would chain decisions made in
  // the same edge and break the load/accept ordering.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: hold, shifter and par_bit are data-path registers that are only
      // read after being written on a load, so they are deliberately left out
      // of reset; hold_full and state gate every use of them.
      state     <= S_IDLE;
      tx_q      <= 1'b1;
      hold_full <= 1'b0;
      baud_cnt  <= '0;
      bit_idx   <= '0;
      stop_cnt  <= 1'b0;
    end else begin
      if (accept) begin
        hold      <= bus.tx_data;
        hold_full <= 1'b1;
      end else if (load) begin
        hold_full <= 1'b0;
      end

      if (load) begin
        shifter  <= hold;
        par_bit  <= par_next;
        state    <= S_START;
        tx_q     <= 1'b0;
        baud_cnt <= '0;
        bit_idx  <= '0;
        stop_cnt <= 1'b0;
      end else if (state != S_IDLE) begin
        if (!bit_end) begin
          baud_cnt <= baud_cnt + 1'b1;
        end else begin
          baud_cnt <= '0;
          case (state)
            S_START: begin
              state <= S_DATA;
              tx_q  <= shifter[0];
            end
            S_DATA: begin
              shifter <= shifter >> 1;
              if (bit_idx == IDX_LAST) begin
                bit_idx <= '0;
                if (PARITY != 0) begin
                  state <= S_PARITY;
                  tx_q  <= par_bit;
                end else begin
                  state <= S_STOP;
                  tx_q  <= 1'b1;
                end
              end else begin
                bit_idx <= bit_idx + 1'b1;
                // Next bit is the one that moves into position 0 this edge.
                tx_q    <= shifter[1];
              end
            end
            S_PARITY: begin
              state <= S_STOP;
              tx_q  <= 1'b1;
            end
            S_STOP: begin
              if (stop_cnt == STOP_LAST) begin
                // Final stop bit with nothing held: return to idle.
                state    <= S_IDLE;
                stop_cnt <= 1'b0;
              end else begin
                stop_cnt <= stop_cnt + 1'b1;
              end
              tx_q <= 1'b1;
            end
            default: begin
              state <= S_IDLE;
              tx_q  <= 1'b1;
            end
          endcase
        end
      end
    end
  end

endmodule
